// File: rtl/ss_pkg.sv
// Shared definitions for ss stream blocks: count-width helper and buffering modes.
package ss_pkg;

  // Width needed to hold values 0..depth inclusive.
  function automatic int ss_cw(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef enum logic {
    SS_CUT_THROUGH = 1'b0,
    SS_STORE_FWD   = 1'b1
  } ss_mode_e;

endpackage

// File: rtl/ss_if.sv
// ss stream interface: data/keep/last/user carried with valid/ready handshake.
interface ss_if #(
  parameter int NUM_BYTES = 8,
  parameter int USER_BITS = 1
);
  logic [NUM_BYTES*8-1:0] data;
  logic [NUM_BYTES-1:0]   keep;
  logic                   valid;
  logic                   last;
  logic [USER_BITS-1:0]   user;
  logic                   ready;

  modport sink   (input  data, keep, valid, last, user, output ready);
  modport source (output data, keep, valid, last, user, input  ready);
endinterface

// File: rtl/ss_fifo_ptr.sv
// Pointer/occupancy tracker for a power-of-two FIFO; callers never push when full or pop when empty.
module ss_fifo_ptr
  import ss_pkg::*;
#(
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = ss_cw(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr
);

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Pointers are exactly log2(DEPTH) bits, so wrap is free.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ss_fifo.sv
// ss stream FIFO with occupancy/packet status and optional store-and-forward release.
module ss_fifo
  import ss_pkg::*;
#(
  parameter int  NUM_BYTES   = 8,
  parameter int  USER_BITS   = 1,
  parameter int  DEPTH       = 16,
  parameter int  PACKET_MODE = 0,
  localparam int CW          = ss_cw(DEPTH),
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  ss_if.sink            in,
  ss_if.source          out,
  output logic [CW-1:0] occupancy,
  output logic [CW-1:0] pkt_count,
  output logic          err_oversize
);

  typedef struct packed {
    logic [NUM_BYTES*8-1:0] data;
    logic [NUM_BYTES-1:0]   keep;
    logic                   last;
    logic [USER_BITS-1:0]   user;
  } beat_t;

  beat_t         mem [DEPTH];
  beat_t         wr_beat, rd_beat;
  logic          push, pop, full, empty, bypass, out_valid;
  logic [CW-1:0] count;
  logic [AW-1:0] wr_ptr, rd_ptr;

  ss_fifo_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .full   (full),
    .empty  (empty),
    .count  (count),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr)
  );

  assign in.ready = !full;
  assign push     = in.valid && !full;
  assign pop      = out_valid && out.ready;

  assign wr_beat = '{data: in.data, keep: in.keep, last: in.last, user: in.user};
  assign rd_beat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_beat;
  end

  always_comb begin
    out_valid = !empty && (PACKET_MODE == 0 || pkt_count != '0 || bypass);
  end

  assign out.valid = out_valid;
  assign out.data  = rd_beat.data;
  assign out.keep  = rd_beat.keep;
  assign out.last  = rd_beat.last;
  assign out.user  = rd_beat.user;

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count <= '0;
    end else begin
      case ({push && in.last, pop && rd_beat.last})
        2'b10:   pkt_count <= pkt_count + 1'b1;
        2'b01:   pkt_count <= pkt_count - 1'b1;
        default: pkt_count <= pkt_count;
      endcase
    end
  end

  // A full buffer with no complete packet can never release one; fall back to
  // cut-through until that oversize packet's last beat drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      bypass       <= 1'b0;
      err_oversize <= 1'b0;
    end else if (PACKET_MODE != 0) begin
      if (pop && rd_beat.last) bypass <= 1'b0;
      if (full && pkt_count == '0) begin
        bypass       <= 1'b1;
        err_oversize <= 1'b1;
      end
    end
  end

  assign occupancy = count;

endmodule

// File: tb/tb_ss_fifo.sv
// Self-checking bench: three ss_fifo configurations against a queue-based reference model.
module tb_ss_fifo;
  import ss_pkg::*;

  localparam int N = 3;
  localparam int DEP [N] = '{4, 8, 4};
  localparam int PM  [N] = '{0, 1, 1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]       v, l, r, u;
  logic [N-1:0][63:0] d;
  logic [N-1:0][7:0]  k;

  logic [N-1:0]       o_v, o_l, o_u, i_r, o_e;
  logic [N-1:0][63:0] o_d;
  logic [N-1:0][7:0]  o_k, o_occ, o_pc;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int D  = DEP[g];
    localparam int CW = ss_cw(D);
    logic [CW-1:0] occ, pc;
    ss_if #(.NUM_BYTES(8), .USER_BITS(1)) si ();
    ss_if #(.NUM_BYTES(8), .USER_BITS(1)) so ();
    assign si.valid = v[g];
    assign si.data  = d[g];
    assign si.keep  = k[g];
    assign si.last  = l[g];
    assign si.user  = u[g];
    assign so.ready = r[g];
    assign i_r[g]   = si.ready;
    assign o_v[g]   = so.valid;
    assign o_d[g]   = so.data;
    assign o_k[g]   = so.keep;
    assign o_l[g]   = so.last;
    assign o_u[g]   = so.user;
    assign o_occ[g] = 8'(occ);
    assign o_pc[g]  = 8'(pc);
    ss_fifo #(.NUM_BYTES(8), .USER_BITS(1), .DEPTH(D), .PACKET_MODE(PM[g])) dut (
      .clk          (clk),
      .rst          (rst),
      .in           (si),
      .out          (so),
      .occupancy    (occ),
      .pkt_count    (pc),
      .err_oversize (o_e[g])
    );
  end

  int tests = 0;
  int fails = 0;
  bit armed = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // Reference model: contents as a queue of {data,keep,last,user}; status derived from it.
  logic [73:0] q [N][$];
  logic        mbp [N];
  logic        merr [N];

  function automatic int nlast(input int i);
    int n = 0;
    foreach (q[i][j]) if (q[i][j][1]) n++;
    return n;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      int sz, np;
      logic ev, er;
      logic [73:0] head, popped;
      sz = q[i].size();
      np = nlast(i);
      ev = (sz != 0) && (PM[i] == 0 || np != 0 || mbp[i]);
      er = (sz != DEP[i]);
      head = (sz != 0) ? q[i][0] : '0;
      if (armed) begin
        chk($sformatf("occ%0d", i),   o_occ[i], 64'(sz));
        chk($sformatf("pkt%0d", i),   o_pc[i],  64'(np));
        chk($sformatf("ready%0d", i), i_r[i],   64'(er));
        chk($sformatf("valid%0d", i), o_v[i],   64'(ev));
        chk($sformatf("err%0d", i),   o_e[i],   64'(merr[i]));
        if (ev) begin
          chk($sformatf("data%0d", i), o_d[i], head[73:10]);
          chk($sformatf("keep%0d", i), o_k[i], 64'(head[9:2]));
          chk($sformatf("last%0d", i), o_l[i], 64'(head[1]));
          chk($sformatf("user%0d", i), o_u[i], 64'(head[0]));
        end
      end
      if (rst) begin
        q[i].delete();
        mbp[i]  = 1'b0;
        merr[i] = 1'b0;
      end else begin
        if (ev && r[i]) begin
          popped = q[i].pop_front();
          if (popped[1]) mbp[i] = 1'b0;
        end
        if (v[i] && er) q[i].push_back({d[i], k[i], l[i], u[i]});
        if (PM[i] != 0 && sz == DEP[i] && np == 0) begin
          mbp[i]  = 1'b1;
          merr[i] = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent, got;
    bit acc, seen, chk_next;
    v = '0; l = '0; r = '0; u = '0; d = '0; k = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    armed = 1;
    for (int i = 0; i < N; i++) begin
      chk("rst_occ",   o_occ[i], 0);
      chk("rst_pkt",   o_pc[i],  0);
      chk("rst_valid", o_v[i],   0);
      chk("rst_ready", i_r[i],   1);
      chk("rst_err",   o_e[i],   0);
    end

    // Fill DEPTH=4 cut-through, hold a 5th beat, simultaneous push/pop at full.
    for (int kk = 0; kk < 4; kk++) begin
      v[0] = 1; d[0] = 64'(100 + kk); k[0] = 8'hff; step();
    end
    d[0] = 64'd104;
    chk("full_occ", o_occ[0], 4);
    chk("full_ready", i_r[0], 0);
    step(); step();
    chk("held_occ", o_occ[0], 4);
    chk("held_head", o_d[0], 100);
    r[0] = 1;
    chk("full_pop_ready", i_r[0], 0);
    step();
    r[0] = 0;
    chk("after_pop_ready", i_r[0], 1);
    step();
    v[0] = 0;
    chk("refill_occ", o_occ[0], 4);
    r[0] = 1;
    for (int kk = 1; kk < 5; kk++) begin
      chk("drain_valid", o_v[0], 1);
      chk("drain_data", o_d[0], 64'(100 + kk));
      step();
    end
    chk("drained_valid", o_v[0], 0);

    // Streaming: 1 beat/cycle, 1-cycle latency, wraps the pointers several times.
    v[0] = 1;
    for (int kk = 0; kk < 20; kk++) begin
      d[0] = 64'(200 + kk);
      step();
      chk("stream_valid", o_v[0], 1);
      chk("stream_data", o_d[0], 64'(200 + kk));
      chk("stream_occ", o_occ[0], 1);
    end
    v[0] = 0;
    step();
    chk("stream_end_occ", o_occ[0], 0);
    r[0] = 0;

    // Store-and-forward, DEPTH=8: 3-beat packet released only after its last beat.
    r[1] = 1;
    for (int kk = 0; kk < 3; kk++) begin
      v[1] = 1; d[1] = 64'(300 + kk); l[1] = (kk == 2); step();
      if (kk < 2) chk("snf_hold_valid", o_v[1], 0);
      else begin
        chk("snf_release_valid", o_v[1], 1);
        chk("snf_pkt", o_pc[1], 1);
      end
    end
    v[1] = 0; l[1] = 0;
    for (int kk = 0; kk < 3; kk++) begin
      chk("snf_valid", o_v[1], 1);
      chk("snf_data", o_d[1], 64'(300 + kk));
      step();
    end
    chk("snf_pkt_end", o_pc[1], 0);
    chk("snf_valid_end", o_v[1], 0);
    r[1] = 0;

    // Oversize 6-beat packet into DEPTH=4 store-and-forward.
    r[2] = 1; v[2] = 1; d[2] = 64'd400; l[2] = 0;
    sent = 0; got = 0; seen = 0; chk_next = 0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      acc = v[2] && i_r[2];
      if (o_v[2] && r[2]) begin
        chk("ovs_data", o_d[2], 64'(400 + got));
        got++;
      end
      step();
      if (acc) begin
        sent++;
        if (sent < 6) begin d[2] = 64'(400 + sent); l[2] = (sent == 5); end
        else begin v[2] = 0; l[2] = 0; end
      end
      if (chk_next) begin
        chk("ovs_err", o_e[2], 1);
        chk("ovs_bypass_valid", o_v[2], 1);
        chk_next = 0;
      end
      if (!seen && o_occ[2] == 8'd4) begin
        chk("ovs_pre_valid", o_v[2], 0);
        seen = 1; chk_next = 1;
      end
    end
    chk("ovs_delivered", 64'(got), 6);
    v[2] = 1; d[2] = 64'd500; step();
    v[2] = 0; step();
    chk("ovs_gated_valid", o_v[2], 0);
    chk("ovs_err_sticky", o_e[2], 1);
    chk("ovs_gated_occ", o_occ[2], 1);
    v[2] = 1; l[2] = 1; d[2] = 64'd501; step();
    v[2] = 0; l[2] = 0;
    chk("ovs_flush_valid", o_v[2], 1);
    step(); step();
    chk("ovs_flush_occ", o_occ[2], 0);
    r[2] = 0;

    // Reset mid-stream with count=3, pkt_count=1.
    r[1] = 0;
    for (int kk = 0; kk < 3; kk++) begin
      v[1] = 1; d[1] = 64'(600 + kk); l[1] = (kk == 1); step();
    end
    v[1] = 0; l[1] = 0;
    chk("pre_rst_occ", o_occ[1], 3);
    chk("pre_rst_pkt", o_pc[1], 1);
    rst = 1; step(); rst = 0;
    chk("mid_rst_occ", o_occ[1], 0);
    chk("mid_rst_pkt", o_pc[1], 0);
    chk("mid_rst_valid", o_v[1], 0);
    chk("mid_rst_ready", i_r[1], 1);
    chk("mid_rst_err", o_e[2], 0);
    r[1] = 1; v[1] = 1; l[1] = 1; d[1] = 64'd700; step();
    v[1] = 0; l[1] = 0;
    chk("post_rst_valid", o_v[1], 1);
    chk("post_rst_data", o_d[1], 700);
    step();
    chk("post_rst_empty", o_v[1], 0);

    // Randomized traffic with shifting backpressure bias.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        v[i] = ($urandom_range(0, 3) != 0);
        r[i] = ((cyc / 256) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
        d[i] = {$urandom, $urandom};
        k[i] = 8'($urandom);
        l[i] = ($urandom_range(0, 4) == 0);
        u[i] = 1'($urandom);
      end
      step();
    end
    v = '0; r = '1;
    repeat (20) step();
    for (int i = 0; i < N; i++) chk("final_occ", o_occ[i], 64'(q[i].size()));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
